// File: rtl/adc_stream_framer.sv
// Sink for a free-running ADC AXI4-Stream: FIFO buffering, programmable-length framing
// with tlast, handshaked output toward the DMA, and status counters.
module adc_stream_framer #(
   parameter int DATA_WIDTH = 32,
   parameter int FIFO_AW    = 4,
   parameter int LEN_WIDTH  = 16
) (
   input  logic                  aclk,
   input  logic                  areset,
   input  logic                  enable,
   input  logic [LEN_WIDTH-1:0]  frame_len,
   input  logic                  flush,
   input  logic                  s_axis_tvalid,
   input  logic [DATA_WIDTH-1:0] s_axis_tdata,
   output logic                  m_axis_tvalid,
   input  logic                  m_axis_tready,
   output logic [DATA_WIDTH-1:0] m_axis_tdata,
   output logic                  m_axis_tlast,
   output logic [FIFO_AW:0]      fifo_level,
   output logic                  overflow,
   input  logic                  clear_status,
   output logic [31:0]           dropped_count,
   output logic [31:0]           words_accepted,
   output logic [31:0]           frames_sent
);

   localparam int DEPTH = 1 << FIFO_AW;

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_RUN   = 2'd1;
   localparam logic [1:0] ST_DRAIN = 2'd2;

   logic [1:0]            state;
   logic [LEN_WIDTH-1:0]  beat_cnt;
   logic [LEN_WIDTH-1:0]  beat_next;
   logic [LEN_WIDTH-1:0]  len_q;
   logic [LEN_WIDTH-1:0]  len_eff;
   logic                  flush_pending;
   logic [FIFO_AW:0]      wr_ptr;
   logic [FIFO_AW:0]      rd_ptr;
   logic [DATA_WIDTH:0]   mem [DEPTH];
   logic                  full;
   logic                  empty;
   logic                  accept;
   logic                  drop;
   logic                  pop;
   logic                  tlast_w;

   // Fullness uses the registered pointers only, so a read in the same cycle cannot rescue a word.
   assign full   = (wr_ptr[FIFO_AW] != rd_ptr[FIFO_AW]) &&
                   (wr_ptr[FIFO_AW-1:0] == rd_ptr[FIFO_AW-1:0]);
   assign empty  = (wr_ptr == rd_ptr);
   assign accept = (state != ST_IDLE) && s_axis_tvalid && !full;
   assign drop   = (state != ST_IDLE) && s_axis_tvalid && full;
   assign pop    = !empty && m_axis_tready;

   assign m_axis_tvalid = !empty;
   assign {m_axis_tlast, m_axis_tdata} = mem[rd_ptr[FIFO_AW-1:0]];
   assign fifo_level = wr_ptr - rd_ptr;

   // The first beat of a frame sees the live frame_len; later beats use the latched length.
   always_comb begin
      len_eff = len_q;
      if (beat_cnt == '0) begin
         len_eff = (frame_len == '0) ? LEN_WIDTH'(1) : frame_len;
      end
      tlast_w   = (beat_cnt == len_eff - LEN_WIDTH'(1)) || flush_pending || flush;
      beat_next = beat_cnt;
      if (accept) begin
         beat_next = tlast_w ? '0 : beat_cnt + LEN_WIDTH'(1);
      end
   end

   always_ff @(posedge aclk or posedge areset) begin
      if (areset) begin
         state <= ST_IDLE;
      end else begin
         case (state)
            ST_IDLE:  if (enable) state <= ST_RUN;
            ST_RUN:   if (!enable) state <= (beat_next == '0) ? ST_IDLE : ST_DRAIN;
            ST_DRAIN: if (accept && tlast_w) state <= ST_IDLE;
            default:  state <= ST_IDLE;
         endcase
      end
   end

   always_ff @(posedge aclk or posedge areset) begin
      if (areset) begin
         beat_cnt      <= '0;
         len_q         <= '0;
         flush_pending <= 1'b0;
      end else begin
         beat_cnt <= beat_next;
         if (accept && beat_cnt == '0) len_q <= len_eff;
         if (accept) flush_pending <= 1'b0;
         else if (flush) flush_pending <= 1'b1;
      end
   end

   always_ff @(posedge aclk or posedge areset) begin
      if (areset) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
      end else begin
         if (accept) begin
            mem[wr_ptr[FIFO_AW-1:0]] <= {tlast_w, s_axis_tdata};
            wr_ptr <= wr_ptr + 1'b1;
         end
         if (pop) rd_ptr <= rd_ptr + 1'b1;
      end
   end

   // A clear in the same cycle as a drop leaves the status cleared.
   always_ff @(posedge aclk or posedge areset) begin
      if (areset) begin
         overflow       <= 1'b0;
         dropped_count  <= '0;
         words_accepted <= '0;
         frames_sent    <= '0;
      end else begin
         if (clear_status) begin
            overflow      <= 1'b0;
            dropped_count <= '0;
         end else if (drop) begin
            overflow <= 1'b1;
            if (dropped_count != 32'hFFFF_FFFF) dropped_count <= dropped_count + 32'd1;
         end
         if (accept) words_accepted <= words_accepted + 32'd1;
         if (pop && m_axis_tlast) frames_sent <= frames_sent + 32'd1;
      end
   end

endmodule

// File: doc/adc_stream_framer.md
Name: adc_stream_framer

Overview:
- Receiving end of the ADC sample stream: a sink for the free-running AXI4-Stream master, which has no tready and cannot be stalled.
- Absorbs jitter in a FIFO, cuts the stream into frames of a programmable length with tlast, and presents a fully handshaked AXI4-Stream master toward the DMA.
- Counts accepted words, completed frames and words dropped on overflow for the status registers.

Parameters:
- DATA_WIDTH, 32, width of s_axis_tdata / m_axis_tdata.
- FIFO_AW, 4, FIFO address width; depth = 2**FIFO_AW words.
- LEN_WIDTH, 16, width of frame_len and of the in-frame beat counter.

Ports:
- aclk  in  1  clock; all logic on the rising edge.
- areset  in  1  asynchronous, active-high reset.
- enable  in  1  1 = accept input words; 0 = ignore input.
- frame_len  in  LEN_WIDTH  words per frame; 0 is treated as 1.
- flush  in  1  single-cycle pulse: close the current frame early.
- s_axis_tvalid  in  1  input word valid; no tready is provided.
- s_axis_tdata  in  DATA_WIDTH  input sample word.
- m_axis_tvalid  out  1  output word valid.
- m_axis_tready  in  1  downstream ready.
- m_axis_tdata  out  DATA_WIDTH  output word.
- m_axis_tlast  out  1  last word of a frame.
- fifo_level  out  FIFO_AW+1  current FIFO occupancy.
- overflow  out  1  sticky flag: at least one word was dropped.
- clear_status  in  1  clears overflow and dropped_count.
- dropped_count  out  32  words lost to FIFO full; saturates at 0xFFFFFFFF.
- words_accepted  out  32  words written into the FIFO; wraps.
- frames_sent  out  32  output handshakes with tlast=1; wraps.

Behaviour:
- Reset: every output and internal register is 0. FIFO is empty, state is IDLE, beat_cnt = 0.
- State machine, input side:
  - IDLE -> RUN when enable=1.
  - RUN -> IDLE when enable=0 and beat_cnt=0.
  - enable=0 with beat_cnt!=0 -> DRAIN: stay there, accept input, complete the frame, then go to IDLE at the tlast write.
  - In IDLE, input is ignored and nothing is counted.
- Accept: word accepted when state != IDLE, s_axis_tvalid=1 and the FIFO is not full.
  - Fullness is evaluated before this cycle's read, so a word arriving while full is dropped even if a read happens in the same cycle.
- Drop: s_axis_tvalid=1, state != IDLE and FIFO full -> word discarded.
  - dropped_count increments (saturating); overflow is set.
  - beat_cnt does not advance.
- Framing at write time: each FIFO entry stores {tlast, data}.
  - len_q latches max(frame_len,1) whenever beat_cnt=0 and a word is accepted.
  - tlast = (beat_cnt == len_q-1), or flush is pending.
  - Each accepted word increments beat_cnt; beat_cnt returns to 0 on a tlast write.
- Flush: the pulse sets flush_pending.
  - The next accepted word is written with tlast=1 and clears flush_pending.
  - Flush with beat_cnt=0 and no further input: no empty frame is produced; pending remains until the next accepted word.
  - flush coincident with an accepted word applies to that word.
- Output: first-word-fall-through.
  - m_axis_tvalid = FIFO not empty; tdata and tlast come from the head entry.
  - Latency: a word accepted in cycle N has m_axis_tvalid=1 in cycle N+1.
  - tdata and tlast are held stable while tvalid=1 and tready=0.
- Pop: on tvalid & tready; frames_sent increments when tlast=1.
  - Simultaneous push and pop leaves fifo_level unchanged.
- Pointers are FIFO_AW+1 bits and wrap naturally; full = MSBs differ with lower bits equal.
- clear_status coincident with a drop: clear wins, so dropped_count=0 and overflow=0.
- frame_len changes mid-frame take effect only at the next frame start.
- Asserting areset mid-frame: the FIFO is emptied and any partial frame is lost with no tlast emitted.

Test Plan:
- frame_len=4, enable=1, 12 consecutive words 0x10..0x1B, m_axis_tready=1 -> 12 output words in order; tlast on 0x13, 0x17, 0x1B; frames_sent=3; first tvalid one cycle after first input.
- FIFO_AW=4, m_axis_tready=0, 20 input words -> fifo_level=16, dropped_count=4, overflow=1; releasing tready outputs exactly the first 16 words; clear_status -> dropped_count=0, overflow=0.
- frame_len=8, 3 words, flush pulse, 2 more words -> tlast on word 4 (flush applies to the next accepted word); next frame restarts counting at word 5.
- frame_len=0 -> every output word has tlast=1; frames_sent equals words_accepted.
- frame_len=6, enable dropped after word 2 -> DRAIN accepts 4 more words, tlast on word 6, then IDLE ignores input; words_accepted=6.
- Random tready backpressure at 50%, 200 words, frame_len=5 -> output sequence identical to input, tdata/tlast stable while stalled, 40 frames, no drops.
